ehl_rom_arbiter: RTL and testbench
==================================

# ehl_rom_arbiter

Round-robin arbiter that shares one synchronous single-port ROM (ehl_rom-style: `rd` strobe, word address, `dout` valid one cycle after `rd`) among NREQ read requesters. It sits between several internal masters (boot sequencer, CPU fetch, DMA) and one ROM instance. It issues at most one ROM read per cycle and routes the returned word back to the granted requester with a one-hot valid. Optional locked bursts let one requester own the ROM for bounded consecutive reads.

## Interface
- NREQ, 4, number of requesters (2..16)
- AWIDTH, 8, ROM word-address width
- DWIDTH, 32, ROM data width
- MAX_LOCK, 16, maximum consecutive grants under lock (1..256); used only with EHL_ROM_ARB_LOCK_EN

- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req  input  NREQ  read request per requester; held with its address until granted
- addr  input  NREQ*AWIDTH  word address, requester i at [i*AWIDTH +: AWIDTH]
- lock  input  NREQ  burst-lock request per requester (present only with EHL_ROM_ARB_LOCK_EN)
- gnt  output  NREQ  one-hot grant, combinational, pulse in the accepting cycle
- rvalid  output  NREQ  one-hot read-data valid, registered, one cycle after gnt
- rdata  output  DWIDTH  shared read data; equals rom_dout
- rom_rd  output  1  ROM read strobe
- rom_addr  output  AWIDTH  ROM word address
- rom_dout  input  DWIDTH  ROM read data, valid the cycle after rom_rd

## Operation
- State: round-robin pointer `ptr` (log2 NREQ bits), pipelined grant index plus valid flag, and, with the lock feature, lock owner, lock-active flag and lock counter.
- Arbitration, each cycle with rst low:
  - If any req is high, exactly one gnt bit is set: the first requesting index searching upward from `ptr`, wrapping modulo NREQ.
  - In the same cycle, rom_rd=1 and rom_addr=addr of the winner. With no req, gnt=0, rom_rd=0 and rom_addr holds its last value.
- Pointer: on a grant to i, ptr <= (i+1) mod NREQ. Without a grant, ptr holds.
- Return path: rvalid[i] is high in the cycle after gnt[i]. rdata is valid only while some rvalid bit is set.
- Requester contract:
  - Keep req and addr stable until gnt. Dropping req before gnt withdraws the request with no side effect.
  - req may stay high after gnt to issue the next read. It is re-arbitrated normally.
- Throughput: one read per cycle aggregate. Worst-case wait for any requester is NREQ-1 cycles (MAX_LOCK*(NREQ-1) with locking).
- Reset, including assertion mid-operation:
  - gnt=0, rvalid=0, rom_rd=0, rom_addr=0, ptr=0, lock state cleared.
  - A read in flight at reset produces no rvalid.
  - rdata is not reset; it follows rom_dout.

## Timing
- Cycle N: req[i] high and selected → gnt[i]=1, rom_rd=1, rom_addr=addr_i (combinational from req/addr and registered state).
- Cycle N+1: rom_dout valid → rvalid[i]=1, rdata=word.
- Back-to-back grants give rvalid on consecutive cycles, in grant order.
- rst deassertion: first grant possible in the first cycle after release.

## Configuration
- EHL_ROM_ARB_LOCK_EN defined:
  - The `lock` port exists.
  - If granted requester i has lock[i]=1 in its grant cycle, lock becomes active with owner=i.
  - While lock is active, i wins whenever req[i]=1 regardless of ptr, and ptr does not advance.
  - Lock releases when req[i]=0 or lock[i]=0 in a cycle, or after MAX_LOCK consecutive locked grants.
  - A release by MAX_LOCK forces the next arbitration to be plain round-robin from (i+1) mod NREQ. The owner cannot re-lock until it has been granted unlocked once.
- Not defined: no `lock` port, no lock state; pure round-robin.

## Structure
- Shared package ehl_rom_arb_pkg: log2 helper function and the default values of NREQ, AWIDTH, DWIDTH and MAX_LOCK.
- Sub-module ehl_rr_pick: combinational round-robin priority picker (req vector, ptr in; one-hot gnt and index out), reused by other codebase arbiters.
- The top level holds the registers, the address mux and the lock logic.

## Test plan
- Single requester: req[2]=1, addr=0x15 with ROM[0x15]=0xCAFE0015 → gnt[2] in cycle N, rvalid[2] with rdata=0xCAFE0015 in N+1, ptr=3.
- All four requesting continuously from reset → grants 0,1,2,3,0… one per cycle, each rvalid carries its own address's word.
- req[1] and req[3] with ptr=2 → gnt[3] first, then gnt[1]; req[3] dropped before grant → no gnt[3], no rvalid[3].
- rst asserted in the cycle after gnt[0] → rvalid[0] never rises, all outputs 0, ptr=0; after release req[1] → gnt[1] in first cycle.
- LOCK_EN, MAX_LOCK=4: req[0]+lock[0] held while req[1]=1 → 4 grants to 0, then gnt[1], then requester 0 is granted again unlocked.
- LOCK_EN: lock[2] dropped after 2 locked grants → next grant goes round-robin from index 3.

Source files
------------

// File: rtl/ehl_rom_arb_pkg.sv
// ehl_rom_arb_pkg
// Shared definitions for the ROM arbiter slice: default parameter values and
// a log2 helper used to size pointer/index/counter fields.
package ehl_rom_arb_pkg;

  localparam int NREQ_DEF     = 4;
  localparam int AWIDTH_DEF   = 8;
  localparam int DWIDTH_DEF   = 32;
  localparam int MAX_LOCK_DEF = 16;

  // ceil(log2(n)), never less than 1 so a field always has at least one bit
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/ehl_rom_arbiter_if.sv
// ehl_rom_arbiter_if
// Requester-side bus of the ROM arbiter.
//   req    : per-requester read request, held with addr until granted
//   addr   : per-requester word address (requester i at addr[i])
//   lock   : per-requester burst lock (only with EHL_ROM_ARB_LOCK_EN)
//   gnt    : one-hot combinational grant
//   rvalid : one-hot read-data valid, one cycle after gnt
//   rdata  : shared read data
// Modports: master (requesters drive req/addr/lock), slave (arbiter).
interface ehl_rom_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int AWIDTH = 8,
  parameter int DWIDTH = 32
);
  logic [NREQ-1:0]             req;
  logic [NREQ-1:0][AWIDTH-1:0] addr;
`ifdef EHL_ROM_ARB_LOCK_EN
  logic [NREQ-1:0]             lock;
`endif
  logic [NREQ-1:0]             gnt;
  logic [NREQ-1:0]             rvalid;
  logic [DWIDTH-1:0]           rdata;

`ifdef EHL_ROM_ARB_LOCK_EN
  modport master (output req, addr, lock, input  gnt, rvalid, rdata);
  modport slave  (input  req, addr, lock, output gnt, rvalid, rdata);
`else
  modport master (output req, addr, input  gnt, rvalid, rdata);
  modport slave  (input  req, addr, output gnt, rvalid, rdata);
`endif
endinterface

// File: rtl/ehl_rr_pick.sv
// ehl_rr_pick
// Combinational round-robin priority picker: the first set bit of i_req
// searching upward from i_ptr, wrapping modulo NREQ.
//   i_req  : request vector
//   i_ptr  : highest-priority index this cycle
//   o_gnt  : one-hot winner (zero when no request)
//   o_idx  : winner index (zero when no request)
//   o_any  : at least one request present
module ehl_rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [PW-1:0]   o_idx,
  output logic            o_any
);
  always_comb begin
    int j;
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(i_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!o_any && i_req[j]) begin
        o_any    = 1'b1;
        o_gnt[j] = 1'b1;
        o_idx    = PW'(j);
      end
    end
  end
endmodule

// File: rtl/ehl_rom_arbiter.sv
// ehl_rom_arbiter
// Round-robin arbiter sharing one synchronous single-port ROM among NREQ
// requesters. One ROM read per cycle; the returned word is routed back with
// a one-hot rvalid one cycle after the grant.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : requester interface (slave modport)
//   rom_rd   : ROM read strobe (same cycle as gnt)
//   rom_addr : ROM word address (holds last value when idle)
//   rom_dout : ROM data, valid the cycle after rom_rd
// Optional feature macro EHL_ROM_ARB_LOCK_EN enables bounded burst locking.
module ehl_rom_arbiter
  import ehl_rom_arb_pkg::*;
#(
  parameter int NREQ     = NREQ_DEF,
  parameter int AWIDTH   = AWIDTH_DEF,
  parameter int DWIDTH   = DWIDTH_DEF,
  parameter int MAX_LOCK = MAX_LOCK_DEF
) (
  input  logic              clk,
  input  logic              rst,
  ehl_rom_arbiter_if.slave  bus,
  output logic              rom_rd,
  output logic [AWIDTH-1:0] rom_addr,
  input  logic [DWIDTH-1:0] rom_dout
);
  localparam int PW = clog2(NREQ);

  if (NREQ < 2 || NREQ > 16) begin : g_bad_nreq
    $error("ehl_rom_arbiter: NREQ out of range 2..16");
  end
  if (MAX_LOCK < 1 || MAX_LOCK > 256) begin : g_bad_lock
    $error("ehl_rom_arbiter: MAX_LOCK out of range 1..256");
  end

  logic [PW-1:0]     r_ptr;
  logic [NREQ-1:0]   r_rvalid;
  logic [AWIDTH-1:0] r_addr_q;

  logic [NREQ-1:0]   w_pick_gnt, w_gnt;
  logic [PW-1:0]     w_pick_idx, w_win;
  logic              w_pick_any, w_any, w_hold;
  logic [AWIDTH-1:0] w_addr;

  ehl_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .i_req (bus.req),
    .i_ptr (r_ptr),
    .o_gnt (w_pick_gnt),
    .o_idx (w_pick_idx),
    .o_any (w_pick_any)
  );

`ifdef EHL_ROM_ARB_LOCK_EN
  localparam int CW = clog2(MAX_LOCK + 1);

  logic          r_lk_act;     // lock active
  logic [PW-1:0] r_lk_own;     // lock owner
  logic [CW-1:0] r_lk_cnt;     // locked grants so far, including the acquiring one
  logic          r_nolk;       // owner released by MAX_LOCK must take one unlocked grant
  logic [PW-1:0] r_nolk_own;
  logic [CW-1:0] w_cnt_nxt;

  // The owner keeps the ROM only while it still asks for it with lock held;
  // otherwise this cycle falls back to plain round-robin.
  assign w_hold    = r_lk_act & bus.req[r_lk_own] & bus.lock[r_lk_own];
  assign w_cnt_nxt = r_lk_cnt + CW'(1);
  assign w_gnt     = rst ? '0 : (w_hold ? (NREQ'(1) << r_lk_own) : w_pick_gnt);
  assign w_win     = w_hold ? r_lk_own : w_pick_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lk_act   <= 1'b0;
      r_lk_own   <= '0;
      r_lk_cnt   <= '0;
      r_nolk     <= 1'b0;
      r_nolk_own <= '0;
    end else if (!w_any) begin
      r_lk_act <= 1'b0;
    end else if (w_hold) begin
      if (w_cnt_nxt == CW'(MAX_LOCK)) begin
        r_lk_act   <= 1'b0;
        r_nolk     <= 1'b1;
        r_nolk_own <= r_lk_own;
      end else begin
        r_lk_cnt <= w_cnt_nxt;
      end
    end else if (r_nolk && r_nolk_own == w_pick_idx) begin
      // the one unlocked grant that re-enables locking for this requester
      r_lk_act <= 1'b0;
      r_nolk   <= 1'b0;
    end else if (bus.lock[w_pick_idx]) begin
      if (MAX_LOCK == 1) begin
        r_lk_act   <= 1'b0;
        r_nolk     <= 1'b1;
        r_nolk_own <= w_pick_idx;
      end else begin
        r_lk_act <= 1'b1;
        r_lk_own <= w_pick_idx;
        r_lk_cnt <= CW'(1);
      end
    end else begin
      r_lk_act <= 1'b0;
    end
  end
`else
  assign w_hold = 1'b0;
  assign w_gnt  = rst ? '0 : w_pick_gnt;
  assign w_win  = w_pick_idx;
`endif

  assign w_any    = |w_gnt;
  assign w_addr   = bus.addr[w_win];
  assign rom_rd   = w_any;
  assign rom_addr = w_any ? w_addr : r_addr_q;
  assign bus.gnt    = w_gnt;
  assign bus.rvalid = r_rvalid;
  assign bus.rdata  = rom_dout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr    <= '0;
      r_rvalid <= '0;
      r_addr_q <= '0;
    end else begin
      r_rvalid <= w_gnt;
      if (w_any) r_addr_q <= w_addr;
      // locked grants leave the pointer where the lock was acquired
      if (w_any && !w_hold)
        r_ptr <= (w_pick_idx == PW'(NREQ - 1)) ? '0 : w_pick_idx + PW'(1);
    end
  end
endmodule

// File: tb/tb_ehl_rom_arbiter.sv
// tb_ehl_rom_arbiter
// Self-checking bench: tasks check grants inline and push the expected
// return word into a scoreboard; a negedge monitor pops and compares rvalid/rdata.
// Lock scenarios run only when EHL_ROM_ARB_LOCK_EN is defined.
module tb_ehl_rom_arbiter;
  localparam int NREQ = 4, AW = 8, DW = 32, MAXL = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rom_rd;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_dout = '0;

  ehl_rom_arbiter_if #(.NREQ(NREQ), .AWIDTH(AW), .DWIDTH(DW)) bus ();

  ehl_rom_arbiter #(.NREQ(NREQ), .AWIDTH(AW), .DWIDTH(DW), .MAX_LOCK(MAXL)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .rom_rd   (rom_rd),
    .rom_addr (rom_addr),
    .rom_dout (rom_dout)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] romw(input logic [AW-1:0] a);
    return {16'hCAFE, 8'h00, a};
  endfunction

  // ROM model: synchronous read, word valid the cycle after rd
  always @(posedge clk) if (rom_rd) rom_dout <= romw(rom_addr);

  typedef struct { int cyc; int idx; logic [DW-1:0] data; } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int cyc = 0;
  int n_tests = 0, n_fail = 0;
  logic [AW-1:0] a_tab [NREQ];
`ifdef EHL_ROM_ARB_LOCK_EN
  logic [NREQ-1:0] lk_nxt = '0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  // return-path scoreboard
  always @(negedge clk) begin
    logic [NREQ-1:0] one;
    if (sb.size() > 0 && sb[0].cyc < cyc) begin
      n_tests++; n_fail++;
      $display("FAIL rvalid_missed: idx %0d expected at cycle %0d, now %0d", sb[0].idx, sb[0].cyc, cyc);
      void'(sb.pop_front());
    end
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      mon_e = sb.pop_front();
      one = NREQ'(1) << mon_e.idx;
      n_tests++;
      if (bus.rvalid !== one || bus.rdata !== mon_e.data) begin
        n_fail++;
        $display("FAIL rvalid_data: got rvalid=%b rdata=%h, want rvalid=%b rdata=%h",
                 bus.rvalid, bus.rdata, one, mon_e.data);
      end
    end else if (bus.rvalid !== '0) begin
      n_tests++; n_fail++;
      $display("FAIL rvalid_unexpected: got rvalid=%b, want 0", bus.rvalid);
    end
  end

  task automatic step(input logic [NREQ-1:0] rq);
    @(posedge clk); #1;
    bus.req = rq;
    for (int i = 0; i < NREQ; i++) bus.addr[i] = a_tab[i];
`ifdef EHL_ROM_ARB_LOCK_EN
    bus.lock = lk_nxt;
`endif
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    bus.req = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.req = '1;
    for (int i = 0; i < NREQ; i++) begin a_tab[i] = AW'(8'h10 + i); bus.addr[i] = a_tab[i]; end
`ifdef EHL_ROM_ARB_LOCK_EN
    bus.lock = '0;
`endif
    repeat (2) @(negedge clk);
    n_tests++; if (bus.gnt !== '0) begin n_fail++; $display("FAIL rst_gnt: got %b want 0", bus.gnt); end
    n_tests++; if (bus.rvalid !== '0) begin n_fail++; $display("FAIL rst_rvalid: got %b want 0", bus.rvalid); end
    n_tests++; if (rom_rd !== 1'b0) begin n_fail++; $display("FAIL rst_rom_rd: got %b want 0", rom_rd); end
    n_tests++; if (rom_addr !== '0) begin n_fail++; $display("FAIL rst_rom_addr: got %h want 0", rom_addr); end
    n_tests++; if (u_dut.r_ptr !== 2'd0) begin n_fail++; $display("FAIL rst_ptr: got %0d want 0", u_dut.r_ptr); end
    bus.req = '0;
    rst = 1'b0;
  endtask

  task automatic test_single();
    a_tab[2] = 8'h15;
    step(4'b0100);
    n_tests++; if (bus.gnt !== 4'b0100) begin n_fail++; $display("FAIL single_gnt: got %b want 0100", bus.gnt); end
    n_tests++; if (rom_rd !== 1'b1 || rom_addr !== 8'h15) begin n_fail++; $display("FAIL single_rom: got rd=%b addr=%h want rd=1 addr=15", rom_rd, rom_addr); end
    sb.push_back('{cyc + 1, 2, 32'hCAFE0015});
    step(4'b0000);
    n_tests++; if (bus.gnt !== '0 || rom_rd !== 1'b0) begin n_fail++; $display("FAIL idle_gnt: got gnt=%b rd=%b want 0", bus.gnt, rom_rd); end
    n_tests++; if (rom_addr !== 8'h15) begin n_fail++; $display("FAIL idle_addr_hold: got %h want 15", rom_addr); end
    n_tests++; if (u_dut.r_ptr !== 2'd3) begin n_fail++; $display("FAIL single_ptr: got %0d want 3", u_dut.r_ptr); end
  endtask

  task automatic test_back_to_back();
    logic [NREQ-1:0] exp;
    pulse_reset();
    for (int i = 0; i < NREQ; i++) a_tab[i] = AW'(8'h40 + 3 * i);
    for (int k = 0; k < 8; k++) begin
      if (k == 4) for (int i = 0; i < NREQ; i++) a_tab[i] = AW'(8'h80 + 5 * i);
      step(4'b1111);
      exp = NREQ'(1) << (k % NREQ);
      n_tests++;
      if (bus.gnt !== exp || rom_addr !== a_tab[k % NREQ]) begin
        n_fail++;
        $display("FAIL rr_gnt[%0d]: got gnt=%b addr=%h want gnt=%b addr=%h", k, bus.gnt, rom_addr, exp, a_tab[k % NREQ]);
      end
      sb.push_back('{cyc + 1, k % NREQ, romw(a_tab[k % NREQ])});
    end
    step(4'b0000);
  endtask

  task automatic test_pair_withdraw();
    // ptr is 0 after the full lap; one grant to 1 moves it to 2
    step(4'b0010);
    n_tests++; if (bus.gnt !== 4'b0010) begin n_fail++; $display("FAIL pair_setup: got %b want 0010", bus.gnt); end
    sb.push_back('{cyc + 1, 1, romw(a_tab[1])});
    step(4'b1010);
    n_tests++; if (bus.gnt !== 4'b1000) begin n_fail++; $display("FAIL pair_first: got %b want 1000", bus.gnt); end
    sb.push_back('{cyc + 1, 3, romw(a_tab[3])});
    step(4'b0010);
    n_tests++; if (bus.gnt !== 4'b0010) begin n_fail++; $display("FAIL pair_second: got %b want 0010", bus.gnt); end
    sb.push_back('{cyc + 1, 1, romw(a_tab[1])});
    step(4'b1100);
    n_tests++; if (bus.gnt !== 4'b0100) begin n_fail++; $display("FAIL withdraw_other: got %b want 0100", bus.gnt); end
    sb.push_back('{cyc + 1, 2, romw(a_tab[2])});
    step(4'b0000);
    n_tests++; if (bus.gnt !== '0) begin n_fail++; $display("FAIL withdraw_gnt: got %b want 0", bus.gnt); end
    step(4'b0000);
  endtask

  task automatic test_reset_inflight();
    pulse_reset();
    step(4'b0001);
    n_tests++; if (bus.gnt !== 4'b0001) begin n_fail++; $display("FAIL inflight_gnt: got %b want 0001", bus.gnt); end
    rst = 1'b1;
    @(negedge clk);
    n_tests++; if (bus.rvalid !== '0 || bus.gnt !== '0 || rom_rd !== 1'b0 || rom_addr !== '0) begin
      n_fail++; $display("FAIL inflight_rst: got rvalid=%b gnt=%b rd=%b addr=%h want all 0", bus.rvalid, bus.gnt, rom_rd, rom_addr);
    end
    n_tests++; if (u_dut.r_ptr !== 2'd0) begin n_fail++; $display("FAIL inflight_ptr: got %0d want 0", u_dut.r_ptr); end
    bus.req = '0;
    rst = 1'b0;
    step(4'b0010);
    n_tests++; if (bus.gnt !== 4'b0010) begin n_fail++; $display("FAIL post_rst_gnt: got %b want 0010", bus.gnt); end
    sb.push_back('{cyc + 1, 1, romw(a_tab[1])});
    step(4'b0000);
  endtask

`ifdef EHL_ROM_ARB_LOCK_EN
  task automatic test_lock_max();
    int seq [8] = '{0, 0, 0, 0, 1, 0, 1, 0};
    logic [NREQ-1:0] exp;
    pulse_reset();
    lk_nxt = 4'b0001;
    for (int k = 0; k < 8; k++) begin
      step(4'b0011);
      exp = NREQ'(1) << seq[k];
      n_tests++;
      if (bus.gnt !== exp) begin n_fail++; $display("FAIL lock_max[%0d]: got %b want %b", k, bus.gnt, exp); end
      sb.push_back('{cyc + 1, seq[k], romw(a_tab[seq[k]])});
    end
    lk_nxt = '0;
    step(4'b0000);
  endtask

  task automatic test_lock_drop();
    pulse_reset();
    lk_nxt = 4'b0100;
    step(4'b0100);
    n_tests++; if (bus.gnt !== 4'b0100) begin n_fail++; $display("FAIL lock_acq: got %b want 0100", bus.gnt); end
    sb.push_back('{cyc + 1, 2, romw(a_tab[2])});
    step(4'b1101);
    n_tests++; if (bus.gnt !== 4'b0100) begin n_fail++; $display("FAIL lock_hold: got %b want 0100", bus.gnt); end
    sb.push_back('{cyc + 1, 2, romw(a_tab[2])});
    lk_nxt = '0;
    step(4'b1101);
    n_tests++; if (bus.gnt !== 4'b1000) begin n_fail++; $display("FAIL lock_drop_rr: got %b want 1000", bus.gnt); end
    sb.push_back('{cyc + 1, 3, romw(a_tab[3])});
    step(4'b0000);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_pair_withdraw();
    test_reset_inflight();
`ifdef EHL_ROM_ARB_LOCK_EN
    test_lock_max();
    test_lock_drop();
`endif
    repeat (3) @(negedge clk);
    n_tests++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL sb_drain: got %0d pending, want 0", sb.size()); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
